// File: rtl/calc_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : State encodings, operator codes and helpers for calc_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int NDIG_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_N1   = 3'd0,
        S_OP   = 3'd1,
        S_N2   = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_if
// Brief    : Sequencer <-> ALU request/acknowledge bus with operands.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_seq_if
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT,
    parameter int OPW  = 2
);
    logic                alu_req;
    logic [4*NDIG-1:0]   num1_bcd;
    logic [4*NDIG-1:0]   num2_bcd;
    logic [OPW-1:0]      operation;
    logic [4*NDIG-1:0]   alu_result;
    logic                alu_ack;
    logic                alu_err;

    modport master (
        output alu_req, num1_bcd, num2_bcd, operation,
        input  alu_result, alu_ack, alu_err
    );

    modport slave (
        input  alu_req, num1_bcd, num2_bcd, operation,
        output alu_result, alu_ack, alu_err
    );
endinterface
`default_nettype wire

// File: rtl/calc_seq_ctrl_entry.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_reg
// Brief    : BCD digit shift register with digit counter, load, clear,
//            overflow strobe and backspace (backspace used with CALC_BACKSPACE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_entry_reg #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load_val,
    input  logic              i_load_dig,
    input  logic              i_del,
    input  logic              i_shift,
    input  logic [3:0]        i_din,
    input  logic [4*NDIG-1:0] i_val,
    output logic [4*NDIG-1:0] o_q,
    output logic [4*NDIG-1:0] o_q_nxt,
    output logic              o_ovf
);
    localparam int W    = 4 * NDIG;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] c_full = CW'(NDIG);
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [W-1:0]  r_q;
    logic [W-1:0]  w_q_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_ovf;

    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
        w_ovf     = 1'b0;
        if (i_clr) begin
            w_q_nxt   = '0;
            w_cnt_nxt = '0;
        end else if (i_load_val) begin
            w_q_nxt   = i_val;
            w_cnt_nxt = c_full;
        end else if (i_load_dig) begin
            w_q_nxt   = {{(W-4){1'b0}}, i_din};
            w_cnt_nxt = c_one;
        end else if (i_del) begin
            if (r_cnt != '0) begin
                w_q_nxt   = {4'h0, r_q[W-1:4]};
                w_cnt_nxt = r_cnt - c_one;
            end
        end else if (i_shift) begin
            // A full register keeps its contents; the extra digit is dropped.
            if (r_cnt == c_full) begin
                w_ovf = 1'b1;
            end else begin
                w_q_nxt   = {r_q[W-5:0], i_din};
                w_cnt_nxt = r_cnt + c_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            r_q   <= w_q_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_q     = r_q;
    assign o_q_nxt = w_q_nxt;
    assign o_ovf   = w_ovf;
endmodule
`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_ctrl
// Brief    : Calculator entry sequencer: operand/operator capture, ALU
//            req/ack, chaining, repeat-equals. Option: CALC_BACKSPACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT,
    parameter int OPW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_num,
    input  logic              is_op,
    input  logic              is_eq,
    input  logic              is_clr,
`ifdef CALC_BACKSPACE_EN
    input  logic              is_del,
`endif
    input  logic [3:0]        num_val,
    input  logic [OPW-1:0]    op_val,
    calc_seq_if.master        alu,
    output logic [4*NDIG-1:0] disp_bcd,
    output logic [2:0]        curr_state,
    output logic              digit_ovf,
    output logic              err
);
    localparam int W = 4 * NDIG;

    state_t         r_state, w_state_nxt;
    logic [OPW-1:0] r_op, w_op_nxt;
    logic [OPW-1:0] r_pend, w_pend_nxt;
    logic           r_chain, w_chain_nxt;
    logic           r_req, r_err, r_ovf;
    logic [W-1:0]   r_disp;

    logic w_clr, w_del, w_eq, w_opev, w_num;
    logic w_n1_clr, w_n1_lval, w_n1_ldig, w_n1_del, w_n1_shift;
    logic w_n2_clr, w_n2_ldig, w_n2_del, w_n2_shift;
    logic [W-1:0] w_n1_q, w_n1_nxt, w_n2_q, w_n2_nxt;
    logic w_n1_ovf, w_n2_ovf;

`ifdef CALC_BACKSPACE_EN
    assign w_del = is_del & ~is_clr;
`else
    assign w_del = 1'b0;
`endif
    // Coincident events resolve as clr > del > eq > op > num.
    assign w_clr  = is_clr;
    assign w_eq   = is_eq & ~w_clr & ~w_del;
    assign w_opev = is_op & ~w_clr & ~w_del & ~is_eq;
    assign w_num  = is_num & is_bcd_digit(num_val) & ~w_clr & ~w_del & ~is_eq & ~is_op;

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_pend_nxt  = r_pend;
        w_chain_nxt = r_chain;
        w_n1_clr    = 1'b0;
        w_n1_lval   = 1'b0;
        w_n1_ldig   = 1'b0;
        w_n1_del    = 1'b0;
        w_n1_shift  = 1'b0;
        w_n2_clr    = 1'b0;
        w_n2_ldig   = 1'b0;
        w_n2_del    = 1'b0;
        w_n2_shift  = 1'b0;
        if (w_clr) begin
            w_state_nxt = S_N1;
            w_op_nxt    = OPW'(OP_ADD);
            w_pend_nxt  = '0;
            w_chain_nxt = 1'b0;
            w_n1_clr    = 1'b1;
            w_n2_clr    = 1'b1;
        end else begin
            case (r_state)
                S_N1: begin
                    w_n1_del   = w_del;
                    w_n1_shift = w_num;
                    if (w_opev) begin
                        w_op_nxt    = op_val;
                        w_state_nxt = S_OP;
                    end
                end
                S_OP: begin
                    if (w_opev) begin
                        w_op_nxt = op_val;
                    end else if (w_num) begin
                        w_n2_ldig   = 1'b1;
                        w_state_nxt = S_N2;
                    end
                end
                S_N2: begin
                    w_n2_del   = w_del;
                    w_n2_shift = w_num;
                    if (w_eq) begin
                        w_chain_nxt = 1'b0;
                        w_state_nxt = S_CALC;
                    end else if (w_opev) begin
                        w_pend_nxt  = op_val;
                        w_chain_nxt = 1'b1;
                        w_state_nxt = S_CALC;
                    end
                end
                S_CALC: begin
                    if (alu.alu_ack) begin
                        if (alu.alu_err) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_n1_lval = 1'b1;
                            if (r_chain) begin
                                w_op_nxt    = r_pend;
                                w_state_nxt = S_OP;
                            end else begin
                                w_state_nxt = S_RES;
                            end
                        end
                    end
                end
                S_RES: begin
                    if (w_eq) begin
                        w_chain_nxt = 1'b0;
                        w_state_nxt = S_CALC;
                    end else if (w_opev) begin
                        w_op_nxt    = op_val;
                        w_state_nxt = S_OP;
                    end else if (w_num) begin
                        w_n1_ldig   = 1'b1;
                        w_n2_clr    = 1'b1;
                        w_state_nxt = S_N1;
                    end
                end
                S_ERR: begin
                    w_state_nxt = S_ERR;
                end
                default: begin
                    w_state_nxt = S_N1;
                end
            endcase
        end
    end

    bcd_entry_reg #(.NDIG(NDIG)) u_num1 (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_n1_clr),
        .i_load_val (w_n1_lval),
        .i_load_dig (w_n1_ldig),
        .i_del      (w_n1_del),
        .i_shift    (w_n1_shift),
        .i_din      (num_val),
        .i_val      (alu.alu_result),
        .o_q        (w_n1_q),
        .o_q_nxt    (w_n1_nxt),
        .o_ovf      (w_n1_ovf)
    );

    bcd_entry_reg #(.NDIG(NDIG)) u_num2 (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_n2_clr),
        .i_load_val (1'b0),
        .i_load_dig (w_n2_ldig),
        .i_del      (w_n2_del),
        .i_shift    (w_n2_shift),
        .i_din      (num_val),
        .i_val      ('0),
        .o_q        (w_n2_q),
        .o_q_nxt    (w_n2_nxt),
        .o_ovf      (w_n2_ovf)
    );

    // Status outputs are derived from next-state values so they align with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_N1;
            r_op    <= '0;
            r_pend  <= '0;
            r_chain <= 1'b0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_disp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_pend  <= w_pend_nxt;
            r_chain <= w_chain_nxt;
            r_req   <= (w_state_nxt == S_CALC);
            r_err   <= (w_state_nxt == S_ERR);
            r_ovf   <= w_n1_ovf | w_n2_ovf;
            r_disp  <= (w_state_nxt == S_N2) ? w_n2_nxt : w_n1_nxt;
        end
    end

    assign alu.alu_req   = r_req;
    assign alu.num1_bcd  = w_n1_q;
    assign alu.num2_bcd  = w_n2_q;
    assign alu.operation = r_op;
    assign disp_bcd      = r_disp;
    assign curr_state    = r_state;
    assign digit_ovf     = r_ovf;
    assign err           = r_err;
endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_seq_ctrl
// Brief    : Self-checking bench for calc_seq_ctrl (NDIG=4, OPW=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_seq_ctrl;
    import calc_pkg::*;

    localparam int K_NUM = 0, K_OP = 1, K_EQ = 2, K_CLR = 3;

    logic clk = 1'b0;
    logic rst;
    logic is_num = 1'b0, is_op = 1'b0, is_eq = 1'b0, is_clr = 1'b0;
    logic is_del = 1'b0;
    logic [3:0]  num_val = '0;
    logic [1:0]  op_val  = '0;
    logic [15:0] disp_bcd;
    logic [2:0]  curr_state;
    logic        digit_ovf, err;

    int n_pass = 0, n_total = 0;
    int req_cycles = 0;

    calc_seq_if #(.NDIG(4), .OPW(2)) alu_if ();

    calc_seq_ctrl #(.NDIG(4), .OPW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .is_num     (is_num),
        .is_op      (is_op),
        .is_eq      (is_eq),
        .is_clr     (is_clr),
`ifdef CALC_BACKSPACE_EN
        .is_del     (is_del),
`endif
        .num_val    (num_val),
        .op_val     (op_val),
        .alu        (alu_if),
        .disp_bcd   (disp_bcd),
        .curr_state (curr_state),
        .digit_ovf  (digit_ovf),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (alu_if.alu_req) req_cycles <= req_cycles + 1;

    typedef struct {
        int          k;
        logic [3:0]  v;
        logic [2:0]  st;
        logic [15:0] n1;
        logic [15:0] n2;
        logic [15:0] disp;
        logic [1:0]  op;
        logic        ovf;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic key(input int k, input logic [3:0] v);
        num_val = v;
        op_val  = v[1:0];
        case (k)
            K_NUM:   is_num = 1'b1;
            K_OP:    is_op  = 1'b1;
            K_EQ:    is_eq  = 1'b1;
            default: is_clr = 1'b1;
        endcase
        @(posedge clk); #1;
        is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0; is_clr = 1'b0;
    endtask

    // ALU model: waits for req, acks after dly cycles with the given result.
    task automatic alu_round(input logic [15:0] res, input logic e, input int dly);
        int t = 0;
        while (!alu_if.alu_req && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!alu_if.alu_req) begin
            check("req_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (dly) begin @(posedge clk); #1; end
        alu_if.alu_result = res;
        alu_if.alu_err    = e;
        alu_if.alu_ack    = 1'b1;
        @(posedge clk); #1;
        alu_if.alu_ack = 1'b0;
        alu_if.alu_err = 1'b0;
    endtask

    initial begin
        int snap;
        alu_if.alu_result = '0;
        alu_if.alu_ack    = 1'b0;
        alu_if.alu_err    = 1'b0;

        vecs[0]  = '{K_NUM, 4'd1,  3'd0, 16'h0001, 16'h0000, 16'h0001, OP_ADD, 1'b0};
        vecs[1]  = '{K_NUM, 4'd2,  3'd0, 16'h0012, 16'h0000, 16'h0012, OP_ADD, 1'b0};
        vecs[2]  = '{K_NUM, 4'd3,  3'd0, 16'h0123, 16'h0000, 16'h0123, OP_ADD, 1'b0};
        vecs[3]  = '{K_NUM, 4'd4,  3'd0, 16'h1234, 16'h0000, 16'h1234, OP_ADD, 1'b0};
        vecs[4]  = '{K_NUM, 4'd5,  3'd0, 16'h1234, 16'h0000, 16'h1234, OP_ADD, 1'b1};
        vecs[5]  = '{K_NUM, 4'd12, 3'd0, 16'h1234, 16'h0000, 16'h1234, OP_ADD, 1'b0};
        vecs[6]  = '{K_EQ,  4'd0,  3'd0, 16'h1234, 16'h0000, 16'h1234, OP_ADD, 1'b0};
        vecs[7]  = '{K_OP,  4'd2,  3'd1, 16'h1234, 16'h0000, 16'h1234, OP_MUL, 1'b0};
        vecs[8]  = '{K_OP,  4'd1,  3'd1, 16'h1234, 16'h0000, 16'h1234, OP_SUB, 1'b0};
        vecs[9]  = '{K_EQ,  4'd0,  3'd1, 16'h1234, 16'h0000, 16'h1234, OP_SUB, 1'b0};
        vecs[10] = '{K_NUM, 4'd7,  3'd2, 16'h1234, 16'h0007, 16'h0007, OP_SUB, 1'b0};
        vecs[11] = '{K_NUM, 4'd8,  3'd2, 16'h1234, 16'h0078, 16'h0078, OP_SUB, 1'b0};
        vecs[12] = '{K_CLR, 4'd0,  3'd0, 16'h0000, 16'h0000, 16'h0000, OP_ADD, 1'b0};

        rst = 1'b0;
        #12;
        check("rst_state", 32'(curr_state), 32'd0);
        check("rst_num1",  32'(alu_if.num1_bcd), 32'd0);
        check("rst_req",   32'(alu_if.alu_req), 32'd0);
        check("rst_disp",  32'(disp_bcd), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            key(vecs[i].k, vecs[i].v);
            check($sformatf("v%0d_state", i), 32'(curr_state), 32'(vecs[i].st));
            check($sformatf("v%0d_num1", i),  32'(alu_if.num1_bcd), 32'(vecs[i].n1));
            check($sformatf("v%0d_num2", i),  32'(alu_if.num2_bcd), 32'(vecs[i].n2));
            check($sformatf("v%0d_disp", i),  32'(disp_bcd), 32'(vecs[i].disp));
            check($sformatf("v%0d_op", i),    32'(alu_if.operation), 32'(vecs[i].op));
            check($sformatf("v%0d_ovf", i),   32'(digit_ovf), 32'(vecs[i].ovf));
        end

        // 12 + 34 = ; ack after two cycles
        key(K_NUM, 4'd1); key(K_NUM, 4'd2); key(K_OP, 4'(OP_ADD));
        key(K_NUM, 4'd3); key(K_NUM, 4'd4); key(K_EQ, 4'd0);
        check("a_state_calc", 32'(curr_state), 32'd3);
        check("a_req",        32'(alu_if.alu_req), 32'd1);
        check("a_num2",       32'(alu_if.num2_bcd), 32'h0034);
        snap = req_cycles;
        alu_round(16'h0046, 1'b0, 2);
        check("a_req_cycles", 32'(req_cycles - snap), 32'd3);
        check("a_num1",       32'(alu_if.num1_bcd), 32'h0046);
        check("a_state",      32'(curr_state), 32'd4);
        check("a_disp",       32'(disp_bcd), 32'h0046);
        check("a_req_low",    32'(alu_if.alu_req), 32'd0);

        // Chain: 9 * 2 + 3 = ; second ack in the first req cycle
        key(K_CLR, 4'd0);
        key(K_NUM, 4'd9); key(K_OP, 4'(OP_MUL)); key(K_NUM, 4'd2); key(K_OP, 4'(OP_ADD));
        check("b_op_calc", 32'(alu_if.operation), 32'(OP_MUL));
        alu_round(16'h0018, 1'b0, 1);
        check("b_state_op", 32'(curr_state), 32'd1);
        check("b_op_chain", 32'(alu_if.operation), 32'(OP_ADD));
        check("b_num1_mid", 32'(alu_if.num1_bcd), 32'h0018);
        key(K_NUM, 4'd3);
        check("b_num2",     32'(alu_if.num2_bcd), 32'h0003);
        key(K_EQ, 4'd0);
        snap = req_cycles;
        alu_round(16'h0021, 1'b0, 0);
        check("b_req_cycles", 32'(req_cycles - snap), 32'd1);
        check("b_num1",       32'(alu_if.num1_bcd), 32'h0021);
        check("b_state",      32'(curr_state), 32'd4);

        // Repeat-equals keeps num2
        key(K_CLR, 4'd0);
        key(K_NUM, 4'd5); key(K_OP, 4'(OP_ADD)); key(K_NUM, 4'd2); key(K_EQ, 4'd0);
        alu_round(16'h0007, 1'b0, 1);
        key(K_EQ, 4'd0);
        check("c_state_calc1", 32'(curr_state), 32'd3);
        alu_round(16'h0009, 1'b0, 1);
        check("c_num1_1", 32'(alu_if.num1_bcd), 32'h0009);
        check("c_num2_1", 32'(alu_if.num2_bcd), 32'h0002);
        key(K_EQ, 4'd0);
        check("c_state_calc2", 32'(curr_state), 32'd3);
        alu_round(16'h0011, 1'b0, 1);
        check("c_num1_2",  32'(alu_if.num1_bcd), 32'h0011);
        check("c_num2_2",  32'(alu_if.num2_bcd), 32'h0002);
        check("c_state",   32'(curr_state), 32'd4);
        key(K_NUM, 4'd4);
        check("c_new_state", 32'(curr_state), 32'd0);
        check("c_new_num1",  32'(alu_if.num1_bcd), 32'h0004);
        check("c_new_num2",  32'(alu_if.num2_bcd), 32'h0000);
        key(K_NUM, 4'd5);
        check("c_new_num1b", 32'(alu_if.num1_bcd), 32'h0045);

        // Divide-by-zero error path
        key(K_CLR, 4'd0);
        key(K_NUM, 4'd8); key(K_OP, 4'(OP_DIV)); key(K_NUM, 4'd0); key(K_EQ, 4'd0);
        alu_round(16'h0000, 1'b1, 1);
        check("d_state", 32'(curr_state), 32'd5);
        check("d_err",   32'(err), 32'd1);
        key(K_NUM, 4'd3);
        check("d_num_ign", 32'(alu_if.num1_bcd), 32'h0008);
        key(K_OP, 4'(OP_SUB));
        check("d_op_ign",  32'(alu_if.operation), 32'(OP_DIV));
        check("d_state2",  32'(curr_state), 32'd5);
        key(K_CLR, 4'd0);
        check("d_clr_state", 32'(curr_state), 32'd0);
        check("d_clr_err",   32'(err), 32'd0);
        check("d_clr_num1",  32'(alu_if.num1_bcd), 32'd0);
        check("d_clr_num2",  32'(alu_if.num2_bcd), 32'd0);
        check("d_clr_op",    32'(alu_if.operation), 32'd0);
        check("d_clr_disp",  32'(disp_bcd), 32'd0);

        // Async reset while a request is outstanding
        key(K_NUM, 4'd1); key(K_OP, 4'(OP_ADD)); key(K_NUM, 4'd2); key(K_EQ, 4'd0);
        check("e_req_hi", 32'(alu_if.alu_req), 32'd1);
        rst = 1'b0;
        #1;
        check("e_req_async", 32'(alu_if.alu_req), 32'd0);
        check("e_state_rst", 32'(curr_state), 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        alu_if.alu_result = 16'h0099;
        alu_if.alu_ack    = 1'b1;
        @(posedge clk); #1;
        alu_if.alu_ack = 1'b0;
        check("e_state", 32'(curr_state), 32'd0);
        check("e_num1",  32'(alu_if.num1_bcd), 32'd0);
        check("e_req",   32'(alu_if.alu_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Parametrised successor of the calculator entry sequencer.
- Captures two BCD operands of NDIG digits each and an operator, then requests the result from the ALU over a req/ack handshake.
- Supports chained operations, repeat-equals, clear and an error state.
- Sits between the keypad decoder (one-cycle event pulses) and the ALU/display path.
- All outputs are registered; no combinational input-to-output paths.

Parameters:
- NDIG, 4, digits per operand; BCD width W = 4*NDIG.
- OPW, 2, operator code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- is_num  in  1  digit event pulse.
- is_op  in  1  operator event pulse.
- is_eq  in  1  equals event pulse.
- is_clr  in  1  clear event pulse.
- num_val  in  4  digit value; values 10-15 are ignored.
- op_val  in  OPW  operator code.
- alu_result  in  W  ALU result, BCD.
- alu_ack  in  1  result valid; one-cycle pulse.
- alu_err  in  1  qualified by alu_ack (overflow or divide-by-zero).
- alu_req  out  1  calculation request.
- num1_bcd  out  W  operand 1 / accumulator.
- num2_bcd  out  W  operand 2.
- operation  out  OPW  operator presented to the ALU.
- disp_bcd  out  W  value to display.
- curr_state  out  3  state, for debug.
- digit_ovf  out  1  one-cycle pulse when a digit is dropped.
- err  out  1  high while in S_ERR.

Behaviour:
- Reset (async, rst=0): state S_N1; all outputs 0; digit counters 0; chain flag 0.
- Event priority if several pulses coincide: clr > eq > op > num.
- is_clr in any state: next edge to S_N1, all registers cleared, alu_req dropped.
- Digit entry: reg <= {reg[W-5:0], num_val}; counter increments.
  - At count==NDIG the digit is dropped and digit_ovf pulses for 1 cycle.
  - num_val > 9 is ignored.
- S_N1 (0):
  - num: shift into num1.
  - op: operation<=op_val, go S_OP.
  - eq: ignored.
- S_OP (1):
  - op: replace operation.
  - num: num2<=digit, cnt2=1, go S_N2.
  - eq: ignored.
- S_N2 (2):
  - num: shift into num2.
  - op: pend_op<=op_val, chain<=1, go S_CALC.
  - eq: chain<=0, go S_CALC.
- S_CALC (3):
  - alu_req=1 from the first cycle in state until the cycle after alu_ack; num/op/eq are ignored.
  - On alu_ack with alu_err=0: num1<=alu_result, cnt1<=NDIG. If chain: operation<=pend_op, go S_OP. Else go S_RES.
  - On alu_ack with alu_err=1: go S_ERR.
  - alu_ack outside S_CALC is ignored.
- S_RES (4):
  - num: num1<=digit, cnt1=1, num2<=0, go S_N1.
  - op: operation<=op_val, go S_OP (result becomes operand 1).
  - eq: repeat the last operation with the unchanged num2, go S_CALC (chain=0).
- S_ERR (5): err=1; only clr exits. States 6-7 recover to S_N1 on the next edge.
- disp_bcd = num2 in S_N2, else num1; registered, so it lags the state by 0 cycles (it is computed from next-state values).
- Latency: event to state change is 1 cycle. Request to result depends on the ALU; the block tolerates ack in the same cycle as the first req.
- Reset during S_CALC: req drops immediately (async). An ack arriving later is ignored.

Optional Feature:
- Macro CALC_BACKSPACE_EN.
- Defined:
  - Adds input is_del (priority between clr and eq).
  - In S_N1/S_N2 it shifts the active operand right 4 bits and decrements its counter; no effect at count 0.
  - Ignored in all other states.
- Undefined: no is_del port; behaviour is otherwise identical.

Decomposition:
- Package calc_pkg:
  - State encodings S_N1..S_ERR.
  - Operator codes: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - Default NDIG.
- Sub-module bcd_entry_reg: W-bit digit shift register with digit counter, load, clear, overflow pulse and optional backspace. Instantiated twice (num1, num2). The FSM stays in the top.

Test Plan:
- Keys 1,2,+,3,4,=; ALU acks 0x0046 after 2 cycles -> alu_req high for exactly 3 cycles, num1=0x0046, state S_RES, disp_bcd=0x0046.
- 5 digits 1..5 with NDIG=4 -> num1=0x1234, one digit_ovf pulse on digit 5.
- 9,*,2,+ (ack 0x0018), 3,= (ack 0x0021) -> after the first ack operation=OP_ADD, state S_OP; final num1=0x0021.
- From S_RES with num2=0x0002, press = twice -> two alu_req/ack rounds, num2 remains 0x0002.
- 8,/,0,= with alu_err=1 on ack -> state S_ERR, err=1; digits and ops ignored; clr -> S_N1, all outputs 0.
- Assert rst=0 mid S_CALC -> alu_req=0 immediately; a subsequent ack leaves state at S_N1, num1=0.
